// File: rtl/uart_receiver.sv
// UART receive stage: oversampled start/data/stop framing with a one-entry
// holding register, a read handshake, and framing/overrun flags.
module uart_receiver #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 serial_in,
    input  logic                 sample_tick,
    input  logic                 read_data,
    output logic [DATA_BITS-1:0] data_bus,
    output logic                 data_ready,
    output logic                 framing_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 rx_meta;
    logic                 rx_s;
    logic                 rx_d;

    // Two-flop synchronizer plus one delay stage for falling-edge detect.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= serial_in;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            data_bus    <= '0;
            data_ready  <= 1'b0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            if (read_data && data_ready) begin
                data_ready  <= 1'b0;
                framing_err <= 1'b0;
                overrun_err <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (rx_d && !rx_s) begin
                        state    <= START;
                        tick_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end

                START: begin
                    if (sample_tick) begin
                        if (tick_cnt == TICK_MID) begin
                            tick_cnt <= '0;
                            if (!rx_s) begin
                                state   <= DATA;
                                bit_cnt <= '0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

                DATA: begin
                    if (sample_tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt  <= '0;
                            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                            bit_cnt   <= bit_cnt + 1'b1;
                            if (bit_cnt == BIT_LAST) begin
                                state <= STOP;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

                STOP: begin
                    if (sample_tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            state    <= IDLE;
                            busy     <= 1'b0;
                            // A read on this edge frees the holder for the new frame.
                            if (!data_ready || read_data) begin
                                data_bus    <= shift_reg;
                                data_ready  <= 1'b1;
                                framing_err <= ~rx_s;
                            end else begin
                                overrun_err <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Randomized self-checking bench for uart_receiver against a
// frame-level model of the holding register and its flags.
module tb_uart_receiver;

    localparam int OS       = 16;
    localparam int DB       = 8;
    localparam int TICK_DIV = 4;

    logic          clk         = 1'b0;
    logic          rstn        = 1'b0;
    logic          serial_in   = 1'b1;
    logic          sample_tick = 1'b0;
    logic          read_data   = 1'b0;
    logic [DB-1:0] data_bus;
    logic          data_ready;
    logic          framing_err;
    logic          overrun_err;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;
    int div      = 0;

    logic [DB-1:0] m_data  = '0;
    logic          m_ready = 1'b0;
    logic          m_ferr  = 1'b0;
    logic          m_ovr   = 1'b0;

    logic [DB+3:0] got;
    logic [DB+3:0] exp;

    uart_receiver #(
        .OVERSAMPLE(OS),
        .DATA_BITS (DB)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .serial_in  (serial_in),
        .sample_tick(sample_tick),
        .read_data  (read_data),
        .data_bus   (data_bus),
        .data_ready (data_ready),
        .framing_err(framing_err),
        .overrun_err(overrun_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        div         = (div + 1) % TICK_DIV;
        sample_tick = (div == 0);
    end

    task automatic tick_edge();
        @(posedge clk);
        while (sample_tick !== 1'b1) @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick_edge();
    endtask

    task automatic model_frame(input logic [DB-1:0] d, input logic stop, input bit rd);
        if (!m_ready || rd) begin
            m_data  = d;
            m_ready = 1'b1;
            m_ferr  = !stop;
            if (rd) m_ovr = 1'b0;
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    task automatic model_read();
        if (m_ready) begin
            m_ready = 1'b0;
            m_ferr  = 1'b0;
            m_ovr   = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_data  = '0;
        m_ready = 1'b0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic snap(input logic exp_busy);
        got = {data_bus, data_ready, framing_err, overrun_err, busy};
        exp = {m_data, m_ready, m_ferr, m_ovr, exp_busy};
    endtask

    // Whole frame, bit boundaries on tick edges; optional read on the completion edge.
    task automatic send_frame(input logic [DB-1:0] d, input logic stop, input bit rd);
        serial_in = 1'b0;
        ticks(OS);
        for (int i = 0; i < DB; i++) begin
            serial_in = d[i];
            ticks(OS);
        end
        serial_in = stop;
        if (rd) begin
            ticks(OS / 2 - 1);
            repeat (TICK_DIV - 1) @(posedge clk);
            #1 read_data = 1'b1;
            tick_edge();
            read_data = 1'b0;
            ticks(OS / 2);
        end else begin
            ticks(OS);
        end
        model_frame(d, stop, rd);
    endtask

    task automatic host_read();
        read_data = 1'b1;
        @(posedge clk);
        #1 read_data = 1'b0;
        model_read();
        tick_edge();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        snap(1'b0);
        n_checks++;
        if (got !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_state: got %h required %h", got, 12'h000);
        end
        rstn = 1'b1;
        ticks(4);
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 1'b1, 1'b0);
        snap(1'b0);
        n_checks++;
        if (got !== exp || exp !== {8'hA5, 4'b1000}) begin
            n_fail++;
            $display("FAIL frame_a5: got %h required %h", got, {8'hA5, 4'b1000});
        end
        host_read();
        snap(1'b0);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL read_a5: got %h required %h", got, exp);
        end
    endtask

    task automatic test_glitch();
        serial_in = 1'b0;
        ticks(4);
        serial_in = 1'b1;
        ticks(1);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_busy: got %b required 1", busy);
        end
        ticks(5);
        snap(1'b0);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL glitch_abort: got %h required %h", got, exp);
        end
        ticks(OS);
    endtask

    task automatic test_framing();
        send_frame(8'h3C, 1'b0, 1'b0);
        snap(1'b0);
        n_checks++;
        if (got !== {8'h3C, 4'b1100}) begin
            n_fail++;
            $display("FAIL framing: got %h required %h", got, {8'h3C, 4'b1100});
        end
        ticks(40);
        snap(1'b0);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL held_low_no_rearm: got %h required %h", got, exp);
        end
        serial_in = 1'b1;
        ticks(4);
        host_read();
        snap(1'b0);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL framing_read: got %h required %h", got, exp);
        end
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        snap(1'b0);
        n_checks++;
        if (got !== {8'h11, 4'b1010}) begin
            n_fail++;
            $display("FAIL overrun: got %h required %h", got, {8'h11, 4'b1010});
        end
        host_read();
        snap(1'b0);
        n_checks++;
        if (got !== {8'h11, 4'b0000}) begin
            n_fail++;
            $display("FAIL overrun_read: got %h required %h", got, {8'h11, 4'b0000});
        end
    endtask

    task automatic test_back_to_back();
        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'hAA, 1'b1, 1'b1);
        snap(1'b0);
        n_checks++;
        if (got !== {8'hAA, 4'b1000}) begin
            n_fail++;
            $display("FAIL back_to_back: got %h required %h", got, {8'hAA, 4'b1000});
        end
        host_read();
    endtask

    task automatic test_reset_mid_frame();
        serial_in = 1'b0;
        ticks(OS);
        for (int i = 0; i < 4; i++) begin
            serial_in = 1'b1;
            ticks(OS);
        end
        ticks(OS / 2);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_mid_frame: got %b required 1", busy);
        end
        rstn = 1'b0;
        #1;
        model_reset();
        snap(1'b0);
        n_checks++;
        if (got !== 12'h000) begin
            n_fail++;
            $display("FAIL async_reset: got %h required %h", got, 12'h000);
        end
        ticks(4);
        rstn = 1'b1;
        ticks(OS);
        send_frame(8'h81, 1'b1, 1'b0);
        snap(1'b0);
        n_checks++;
        if (got !== {8'h81, 4'b1000}) begin
            n_fail++;
            $display("FAIL after_reset_81: got %h required %h", got, {8'h81, 4'b1000});
        end
        host_read();
    endtask

    task automatic test_random();
        logic [DB-1:0] d;
        logic          stop;
        bit            rd;
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 2) == 0) host_read();
            d    = DB'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            rd   = ($urandom_range(0, 3) == 0);
            send_frame(d, stop, rd);
            snap(1'b0);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random_frame_%0d: got %h required %h", n, got, exp);
            end
            serial_in = 1'b1;
            ticks(stop ? $urandom_range(0, 2) : 2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_overrun();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
